gesture_code_matcher: RTL
=========================

// Module: gesture_code_matcher
// PURPOSE
//  Parametrised proximity-gesture code lock for the door-lock datapath. Samples the
//  binary near/far signal once per internal sample tick and matches it against one of
//  NUM_CODES selectable CODE_LEN-bit codes. Adds auto-relock, forced relock,
//  failed-attempt counting with timed lockout, and progress/status outputs.
//  Sits between unlock_signal_binary and hexout/LED drivers.
// PARAMETERS
//  CODE_LEN      9         bits per code; valid range 1..32
//  NUM_CODES     4         number of selectable codes; >=1
//  SAMPLE_DIV    25000000  clock cycles per sample tick; >=2; 2 Hz at 50 MHz
//  MAX_FAILS     3         consecutive mismatches that trigger lockout; >=1
//  LOCKOUT_TICKS 20        sample ticks spent in LOCKOUT
//  UNLOCK_TICKS  10        sample ticks spent in UNLOCKED before auto-relock
// PORTS
//  clock       in   1                       system clock (CLOCK_50)
//  reset       in   1                       asynchronous, active-high
//  near        in   1                       raw binary proximity; async, synchronised internally
//  codes       in   NUM_CODES*CODE_LEN      code k = codes[k*CODE_LEN +: CODE_LEN]; MSB entered first
//  code_sel    in   max(1,$clog2(NUM_CODES)) selects active code
//  lock_req    in   1                       level; forces relock / aborts entry
//  tick        out  1                       one-cycle sample strobe (LED heartbeat)
//  progress    out  $clog2(CODE_LEN+1)      bits matched so far
//  fail_count  out  $clog2(MAX_FAILS+1)     consecutive failed attempts
//  unlocked    out  1                       high in UNLOCKED
//  locked_out  out  1                       high in LOCKOUT
//  state       out  2                       IDLE=0 ENTRY=1 UNLOCKED=2 LOCKOUT=3
// BEHAVIOUR
//  - Reset, async: all outputs 0, state IDLE, divider 0, sync flops 0, latched code 0.
//  - near passes a 2-flop synchroniser; near_s = synchronised value.
//  - Divider counts 0..SAMPLE_DIV-1. tick=1 when count==SAMPLE_DIV-1.
//    First tick occurs SAMPLE_DIV cycles after reset release. FSM acts only on tick,
//    except lock_req handling.
//  - All outputs registered. State effects appear the cycle after the deciding tick.
//  - IDLE, on tick:
//    - code_sel>=NUM_CODES: stay; no fail.
//    - near_s=1 and selected code MSB=1: latch selected code.
//      - CODE_LEN==1: UNLOCKED, fail_count=0.
//      - else ENTRY, progress=1.
//    - near_s=1 and MSB=0: fail.
//    - near_s=0: stay; no fail.
//  - ENTRY, on tick: compare near_s with latched[CODE_LEN-1-progress].
//    - equal: progress+1. If this reaches CODE_LEN: UNLOCKED, progress=0, fail_count=0.
//    - unequal: fail, progress=0. The failing sample is not re-evaluated as a new start.
//    - code_sel changes during ENTRY have no effect (code latched).
//  - Fail: fail_count+1.
//    - If result==MAX_FAILS: LOCKOUT, timer=0.
//    - else IDLE.
//  - UNLOCKED: timer counts ticks; after UNLOCK_TICKS ticks -> IDLE, timer=0.
//    near ignored.
//  - LOCKOUT: near and lock_req ignored. After LOCKOUT_TICKS ticks -> IDLE, fail_count=0.
//  - lock_req=1, checked every cycle, has priority over tick:
//    - UNLOCKED: -> IDLE next cycle.
//    - ENTRY: -> IDLE, progress=0, fail_count unchanged.
//    - IDLE: no effect.
//  - fail_count saturates at MAX_FAILS. All counters are sized to never wrap.
// TESTING  (SAMPLE_DIV=4, CODE_LEN=9, NUM_CODES=4, MAX_FAILS=3, LOCKOUT_TICKS=5,
//  UNLOCK_TICKS=3; codes 110111001,101000110,110001110,100110001; near changed
//  mid-period, tick-aligned after sync)
//  1 Reset during ENTRY with progress=5 -> all outputs 0 immediately; first tick 4 cycles
//    after release.
//  2 code_sel=0, feed 1,1,0,1,1,1,0,0,1 -> progress 1..8; unlocked=1 the cycle after
//    tick 9; unlocked=0 after 3 more ticks; state back to 0.
//  3 code_sel=0, feed 1,1,1 -> third tick: fail_count=1, progress=0, state=IDLE,
//    unlocked never 1.
//  4 Three failed attempts -> locked_out=1, state=3; near pulses ignored for 5 ticks;
//    then state=0, fail_count=0.
//  5 Start code 1 (101000110), switch code_sel to 2 after 3 bits, finish code-1
//    sequence -> unlocked=1.
//  6 In UNLOCKED, assert lock_req for 1 cycle -> unlocked=0 next cycle. In ENTRY at
//    progress=4, assert lock_req -> progress=0, fail_count unchanged.

Source files
------------

// File: rtl/gesture_code_matcher.sv
// gesture_code_matcher
//   Proximity-gesture code lock. The near/far input is synchronised and sampled
//   once per internal sample tick. The samples are matched MSB-first against one
//   of NUM_CODES selectable codes. The block also provides auto-relock, forced
//   relock, failed-attempt counting with a timed lockout, and progress/status
//   outputs.
// Ports
//   clock, reset  system clock; asynchronous active-high reset
//   near          raw proximity bit (asynchronous to clock)
//   codes         packed code table, code k = codes[k*CODE_LEN +: CODE_LEN]
//   code_sel      index of the active code (sampled when an entry starts)
//   lock_req      level; forces relock / aborts an entry in progress
//   tick          one-cycle sample strobe
//   progress      bits matched so far in the current entry
//   fail_count    consecutive failed attempts (saturating)
//   unlocked      high in UNLOCKED
//   locked_out    high in LOCKOUT
//   state         IDLE=0 ENTRY=1 UNLOCKED=2 LOCKOUT=3
module gesture_code_matcher #(
  parameter int CODE_LEN      = 9,
  parameter int NUM_CODES     = 4,
  parameter int SAMPLE_DIV    = 25000000,
  parameter int MAX_FAILS     = 3,
  parameter int LOCKOUT_TICKS = 20,
  parameter int UNLOCK_TICKS  = 10,
  localparam int SEL_W  = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1,
  localparam int PROG_W = $clog2(CODE_LEN + 1),
  localparam int FAIL_W = $clog2(MAX_FAILS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          near,
  input  logic [NUM_CODES*CODE_LEN-1:0] codes,
  input  logic [SEL_W-1:0]              code_sel,
  input  logic                          lock_req,
  output logic                          tick,
  output logic [PROG_W-1:0]             progress,
  output logic [FAIL_W-1:0]             fail_count,
  output logic                          unlocked,
  output logic                          locked_out,
  output logic [1:0]                    state
);

  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int TMR_MAX = (LOCKOUT_TICKS > UNLOCK_TICKS) ? LOCKOUT_TICKS : UNLOCK_TICKS;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  sync1_q, sync2_q;
  logic [CODE_LEN-1:0]   code_q, code_d;
  logic [PROG_W-1:0]     prog_q, prog_d;
  logic [FAIL_W-1:0]     fail_q, fail_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  tick_q, unlocked_q, locked_out_q;

  logic                  tick_int;
  logic                  near_s;
  logic                  sel_ok;
  logic [CODE_LEN-1:0]   sel_code;
  logic [CODE_LEN-1:0]   code_shift;
  logic                  exp_bit;
  logic                  do_fail;
  logic [FAIL_W-1:0]     fail_inc;

  assign near_s = sync2_q;

  // Sample divider: wraps at SAMPLE_DIV-1, which is the deciding cycle.
  always_comb begin
    tick_int = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d    = tick_int ? '0 : div_q + 1'b1;
  end

  // Code table mux; an out-of-range selector never starts an entry.
  always_comb begin
    sel_ok   = (int'(code_sel) < NUM_CODES);
    sel_code = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      if (int'(code_sel) == k) sel_code = codes[k*CODE_LEN +: CODE_LEN];
    end
  end

  // The next expected bit is latched[CODE_LEN-1-progress]. It is taken by
  // shifting the already-matched bits out of the top of the latched code.
  always_comb begin
    code_shift = code_q << prog_q;
    exp_bit    = code_shift[CODE_LEN-1];
  end

  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    code_d   = code_q;
    do_fail  = 1'b0;
    fail_inc = (fail_q == FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

    if (lock_req && (state_q == ENTRY || state_q == UNLOCKED)) begin
      // Forced relock wins over a coincident tick; fail_count is left alone.
      state_d = IDLE;
      prog_d  = '0;
      timer_d = '0;
    end else if (tick_int) begin
      case (state_q)
        IDLE: begin
          if (sel_ok && near_s) begin
            if (sel_code[CODE_LEN-1]) begin
              code_d = sel_code;
              if (CODE_LEN == 1) begin
                state_d = UNLOCKED;
                fail_d  = '0;
                timer_d = '0;
              end else begin
                state_d = ENTRY;
                prog_d  = PROG_W'(1);
              end
            end else begin
              do_fail = 1'b1;
            end
          end
        end
        ENTRY: begin
          if (near_s == exp_bit) begin
            if (int'(prog_q) + 1 == CODE_LEN) begin
              state_d = UNLOCKED;
              prog_d  = '0;
              fail_d  = '0;
              timer_d = '0;
            end else begin
              prog_d = prog_q + 1'b1;
            end
          end else begin
            do_fail = 1'b1;
          end
        end
        UNLOCKED: begin
          if (int'(timer_q) + 1 >= UNLOCK_TICKS) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        LOCKOUT: begin
          if (int'(timer_q) + 1 >= LOCKOUT_TICKS) begin
            state_d = IDLE;
            timer_d = '0;
            fail_d  = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // A failing sample ends the attempt outright; it is not reused as a start.
      if (do_fail) begin
        prog_d = '0;
        fail_d = fail_inc;
        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
          state_d = LOCKOUT;
          timer_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      code_q       <= '0;
      prog_q       <= '0;
      fail_q       <= '0;
      timer_q      <= '0;
      tick_q       <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sync1_q      <= near;
      sync2_q      <= sync1_q;
      code_q       <= code_d;
      prog_q       <= prog_d;
      fail_q       <= fail_d;
      timer_q      <= timer_d;
      tick_q       <= tick_int;
      unlocked_q   <= (state_d == UNLOCKED);
      locked_out_q <= (state_d == LOCKOUT);
    end
  end

  assign tick       = tick_q;
  assign progress   = prog_q;
  assign fail_count = fail_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign state      = state_q;

endmodule
